// File: rtl/window_fill_ctrl.sv
// ---------------------------------------------------------------------------
// window_fill_ctrl
//
// Sequencer for the 25-entry 5x5 window buffer of the edge-detection
// pipeline. Walks every 5x5 window of an IMG_W x IMG_H image in raster order.
// For each window it clears the buffer, fetches the 25 pixels from image
// memory one at a time, saves each into the buffer, waits for the buffer to
// report full, then starts the edge calculator and waits for it to finish.
//
// Ports
//   clk, n_rst      clock (rising edge), asynchronous active-low reset
//   i_start         begin a frame (only honoured in IDLE)
//   i_abort         abandon the frame: one clear pulse, then IDLE
//   o_rd_req        one-cycle memory read request, address on o_rd_addr
//   i_rd_valid      read data valid, pixel on i_rd_data
//   o_save, o_data  save pulse and pixel towards the window buffer
//   o_clear         clear pulse towards the window buffer
//   i_buf_full      window buffer full / empty flags
//   i_buf_empty
//   o_calc_start    one-cycle start pulse to the edge calculator
//   i_calc_done     calculator finished the current window
//   o_win_row/col   top-left corner of the current window
//   o_busy          high whenever not IDLE
//   o_frame_done    one-cycle pulse after the last window completes
// ---------------------------------------------------------------------------
module window_fill_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [7:0]        i_rd_data,
  output logic              o_save,
  output logic [7:0]        o_data,
  output logic              o_clear,
  input  logic              i_buf_full,
  input  logic              i_buf_empty,
  output logic              o_calc_start,
  input  logic              i_calc_done,
  output logic [ADDR_W-1:0] o_win_row,
  output logic [ADDR_W-1:0] o_win_col,
  output logic              o_busy,
  output logic              o_frame_done
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, WAIT_EMPTY, REQ, WAIT_DATA, SAVE,
    HOLD, WAIT_FULL, CALC, WAIT_CALC, ADVANCE, DONE
  } state_e;

  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 5);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 5);

  state_e            state_q, state_d;
  logic              abort_q, abort_d;     // current CLEAR is an abort clear
  logic [2:0]        kr_q, kr_d;           // element row inside the window
  logic [2:0]        kc_q, kc_d;           // element column inside the window
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              rd_req_q, save_q, clear_q, calc_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        row_d   = '0;
        col_d   = '0;
        kr_d    = '0;
        kc_d    = '0;
        abort_d = 1'b0;
        if (i_start && !i_abort) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = abort_q ? IDLE : WAIT_EMPTY;
        abort_d = 1'b0;
      end
      WAIT_EMPTY: if (i_buf_empty) state_d = REQ;
      REQ:        state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (i_rd_valid) begin
          data_d  = i_rd_data;
          state_d = SAVE;
        end
      end
      SAVE: state_d = HOLD;
      HOLD: begin
        state_d = REQ;
        if (kc_q == 3'd4) begin
          kc_d = '0;
          if (kr_q == 3'd4) begin
            kr_d    = '0;
            state_d = WAIT_FULL;
          end else begin
            kr_d = kr_q + 3'd1;
          end
        end else begin
          kc_d = kc_q + 3'd1;
        end
      end
      WAIT_FULL: if (i_buf_full) state_d = CALC;
      CALC:      state_d = WAIT_CALC;
      WAIT_CALC: if (i_calc_done) state_d = ADVANCE;
      ADVANCE: begin
        kr_d = '0;
        kc_d = '0;
        if (col_q < COL_LAST) begin
          col_d   = col_q + 1'b1;
          state_d = CLEAR;
        end else if (row_q < ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          state_d = CLEAR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition; a pixel arriving in the same cycle
    // is dropped so the buffer never sees it.
    if (i_abort && (state_q != IDLE)) begin
      state_d = CLEAR;
      abort_d = 1'b1;
      data_d  = data_q;
    end

    // Address is formed from the next-state counters so it is registered
    // together with the request pulse.
    if ((state_d == REQ) && (state_q != REQ)) begin
      addr_d = (row_d + ADDR_W'(kr_d)) * IMG_W_A + col_d + ADDR_W'(kc_d);
    end
  end

  // Outputs are decoded from the next state and registered, so each pulse is
  // high exactly while the FSM sits in the corresponding state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      abort_q  <= 1'b0;
      kr_q     <= '0;
      kc_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_req_q <= 1'b0;
      save_q   <= 1'b0;
      clear_q  <= 1'b0;
      calc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      abort_q  <= abort_d;
      kr_q     <= kr_d;
      kc_q     <= kc_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_req_q <= (state_d == REQ);
      save_q   <= (state_d == SAVE);
      clear_q  <= (state_d == CLEAR);
      calc_q   <= (state_d == CALC);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign o_rd_req     = rd_req_q;
  assign o_rd_addr    = addr_q;
  assign o_save       = save_q;
  assign o_data       = data_q;
  assign o_clear      = clear_q;
  assign o_calc_start = calc_q;
  assign o_win_row    = row_q;
  assign o_win_col    = col_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_window_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_fill_ctrl
//
// Bench for window_fill_ctrl on an 8x6 image (8 windows, 200 reads per
// frame). Behavioural models stand in for image memory (pixel = address,
// programmable latency), the window buffer (save counter, full flag after a
// programmable delay) and the calculator (done 3 cycles after start).
// Expected read addresses are queued when a frame is started and popped as
// the DUT issues reads; saved pixels are checked against the queued address.
// ---------------------------------------------------------------------------
module tb_window_fill_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 16;
  localparam int NWIN = (W - 4) * (H - 4);

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          i_start, i_abort;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic          i_rd_valid;
  logic [7:0]    i_rd_data;
  logic          o_save;
  logic [7:0]    o_data;
  logic          o_clear;
  logic          i_buf_full, i_buf_empty;
  logic          o_calc_start;
  logic          i_calc_done;
  logic [AW-1:0] o_win_row, o_win_col;
  logic          o_busy, o_frame_done;

  // bench-driven stimulus
  logic start_drv = 1'b0;
  logic abort_drv = 1'b0;
  logic cdone_inj = 1'b0;
  int   mem_lat = 1;
  int   full_delay = 2;

  always #5 clk = ~clk;

  window_fill_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_start(i_start), .i_abort(i_abort),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_save(o_save), .o_data(o_data), .o_clear(o_clear),
    .i_buf_full(i_buf_full), .i_buf_empty(i_buf_empty),
    .o_calc_start(o_calc_start), .i_calc_done(i_calc_done),
    .o_win_row(o_win_row), .o_win_col(o_win_col),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  assign i_start = start_drv;
  assign i_abort = abort_drv;

  // ---- image memory model: one outstanding read, pixel = address --------
  int            mem_cnt;
  logic [AW-1:0] mem_addr;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (o_rd_req) begin
      mem_cnt  <= mem_lat;
      mem_addr <= o_rd_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end
  assign i_rd_valid = (mem_cnt == 1);
  assign i_rd_data  = i_rd_valid ? mem_addr[7:0] : 8'h00;

  // ---- window buffer model ------------------------------------------------
  int bcnt, bsince;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bcnt   <= 0;
      bsince <= 0;
    end else if (o_clear) begin
      bcnt   <= 0;
      bsince <= 0;
    end else if (o_save) begin
      bcnt <= bcnt + 1;
    end else if (bcnt == 25) begin
      bsince <= bsince + 1;
    end
  end
  assign i_buf_empty = (bcnt == 0);
  assign i_buf_full  = (bcnt == 25) && (bsince >= full_delay);

  // ---- calculator model ---------------------------------------------------
  int ccnt;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)            ccnt <= 0;
    else if (o_calc_start) ccnt <= 3;
    else if (ccnt != 0)    ccnt <= ccnt - 1;
  end
  assign i_calc_done = (ccnt == 1) | cdone_inj;

  // ---- scoreboard and counters -------------------------------------------
  logic [AW-1:0] exp_addr_q[$];
  logic [7:0]    exp_data_q[$];
  int tests = 0;
  int fails = 0;
  int n_reads, n_saves, n_clears, n_calcs, n_dones;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_reads = 0; n_saves = 0; n_clears = 0; n_calcs = 0; n_dones = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic push_frame();
    for (int r = 0; r <= H - 5; r++)
      for (int c = 0; c <= W - 5; c++)
        for (int kr = 0; kr < 5; kr++)
          for (int kc = 0; kc < 5; kc++)
            exp_addr_q.push_back(AW'((r + kr) * W + c + kc));
  endtask

  // Samples DUT outputs on the falling edge.
  task automatic monitor();
    int            since_save = 100;
    logic          prev_valid = 1'b0;
    logic          hold_pend = 1'b0;
    logic [7:0]    held_data = '0;
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      since_save++;
      if (hold_pend) begin
        hold_pend = 1'b0;
        chk("data_hold", o_data, held_data);
      end
      if (o_rd_req) begin
        n_reads++;
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_addr: got %0d, expected no read", o_rd_addr);
        end else begin
          e = exp_addr_q.pop_front();
          chk("rd_addr", o_rd_addr, e);
          exp_data_q.push_back(e[7:0]);
        end
      end
      if (o_save) begin
        n_saves++;
        chk("save_after_valid", prev_valid, 1);
        chk("save_spacing", (since_save >= 3) ? 1 : 0, 1);
        since_save = 0;
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL save_data: got %0d, expected no save", o_data);
        end else begin
          chk("save_data", o_data, exp_data_q.pop_front());
        end
        held_data = o_data;
        hold_pend = 1'b1;
      end
      if (o_clear) n_clears++;
      if (o_calc_start) begin
        chk("calc_when_full", i_buf_full, 1);
        chk("win_row", o_win_row, n_calcs / (W - 4));
        chk("win_col", o_win_col, n_calcs % (W - 4));
        n_calcs++;
      end
      if (o_frame_done) n_dones++;
      prev_valid = i_rd_valid;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_drv = 1'b1;
    @(posedge clk); #1 start_drv = 1'b0;
  endtask

  task automatic pulse_spurious();
    #1 start_drv = 1'b1; cdone_inj = 1'b1;
    @(posedge clk); #1 start_drv = 1'b0; cdone_inj = 1'b0;
  endtask

  task automatic run_frame(input bit inject);
    int cyc;
    bit inj1, inj2;
    clear_counts();
    push_frame();
    pulse_start();
    cyc = 0; inj1 = 0; inj2 = 0;
    while (n_dones == 0 && cyc < 10000) begin
      @(posedge clk);
      cyc++;
      if (inject && !inj1 && n_reads >= 10) begin inj1 = 1; pulse_spurious(); end
      if (inject && !inj2 && n_reads >= 60) begin inj2 = 1; pulse_spurious(); end
    end
    chk("frame_in_budget", (cyc < 10000) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
  endtask

  task automatic check_frame_counts(input string tag);
    chk({tag, "_reads"},  n_reads,  NWIN * 25);
    chk({tag, "_saves"},  n_saves,  NWIN * 25);
    chk({tag, "_clears"}, n_clears, NWIN);
    chk({tag, "_calcs"},  n_calcs,  NWIN);
    chk({tag, "_dones"},  n_dones,  1);
    chk({tag, "_busy"},   o_busy,   0);
    chk({tag, "_left"},   exp_addr_q.size(), 0);
  endtask

  typedef struct {
    int lat;
    int fdelay;
    bit inject;
    int exp_reads;
    int exp_saves;
    int exp_clears;
    int exp_calcs;
    int exp_dones;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    // {memory latency, full delay, spurious start/done, expected counts}
    vecs[0] = '{1, 2,  1'b0, 200, 200, 8, 8, 1};
    vecs[1] = '{5, 2,  1'b0, 200, 200, 8, 8, 1};
    vecs[2] = '{1, 12, 1'b0, 200, 200, 8, 8, 1};
    vecs[3] = '{2, 2,  1'b1, 200, 200, 8, 8, 1};

    clear_counts();
    fork
      monitor();
    join_none

    // reset values
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulses", {o_rd_req, o_save, o_clear, o_calc_start, o_frame_done, o_busy}, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_win", {o_win_row, o_win_col}, 0);
    @(negedge clk) n_rst = 1'b1;

    // start and abort together in IDLE: abort wins
    clear_counts();
    @(posedge clk); #1 start_drv = 1'b1; abort_drv = 1'b1;
    @(posedge clk); #1 start_drv = 1'b0; abort_drv = 1'b0;
    repeat (4) @(posedge clk);
    chk("start_abort_busy", o_busy, 0);
    chk("start_abort_clears", n_clears, 0);
    $display("[TB] start+abort in IDLE: busy=%0d clears=%0d", o_busy, n_clears);

    // table-driven full frames
    for (int i = 0; i < 4; i++) begin
      mem_lat    = vecs[i].lat;
      full_delay = vecs[i].fdelay;
      run_frame(vecs[i].inject);
      chk("vec_reads",  n_reads,  vecs[i].exp_reads);
      chk("vec_saves",  n_saves,  vecs[i].exp_saves);
      chk("vec_clears", n_clears, vecs[i].exp_clears);
      chk("vec_calcs",  n_calcs,  vecs[i].exp_calcs);
      chk("vec_dones",  n_dones,  vecs[i].exp_dones);
      chk("vec_busy",   o_busy,   0);
      chk("vec_left",   exp_addr_q.size(), 0);
      $display("[TB] vec %0d lat=%0d fdelay=%0d inject=%0d: reads=%0d saves=%0d clears=%0d calcs=%0d dones=%0d",
               i, vecs[i].lat, vecs[i].fdelay, vecs[i].inject,
               n_reads, n_saves, n_clears, n_calcs, n_dones);
    end

    // abort in WAIT_DATA of window 2, element 7
    mem_lat = 5; full_delay = 2;
    clear_counts();
    push_frame();
    pulse_start();
    cyc = 0;
    while (n_reads < 58 && cyc < 10000) begin
      @(posedge clk);
      cyc++;
    end
    chk("abort_reached", (n_reads == 58) ? 1 : 0, 1);
    #1 abort_drv = 1'b1;
    @(posedge clk); #1 abort_drv = 1'b0;
    @(negedge clk);
    chk("abort_clear_on", o_clear, 1);
    chk("abort_busy_on", o_busy, 1);
    @(negedge clk);
    chk("abort_clear_off", o_clear, 0);
    chk("abort_idle", o_busy, 0);
    repeat (10) @(posedge clk);
    chk("abort_clears", n_clears, 4);
    chk("abort_saves", n_saves, 57);
    chk("abort_no_done", n_dones, 0);
    $display("[TB] abort: reads=%0d saves=%0d clears=%0d dones=%0d", n_reads, n_saves, n_clears, n_dones);
    mem_lat = 1;
    run_frame(1'b0);
    check_frame_counts("after_abort");
    $display("[TB] restart after abort: reads=%0d calcs=%0d dones=%0d", n_reads, n_calcs, n_dones);

    // reset during WAIT_CALC of window 3
    clear_counts();
    push_frame();
    pulse_start();
    cyc = 0;
    while (n_calcs < 4 && cyc < 10000) begin
      @(posedge clk);
      cyc++;
    end
    chk("rst_mid_reached", (n_calcs == 4) ? 1 : 0, 1);
    #1 n_rst = 1'b0;
    #1;
    chk("rst_mid_pulses", {o_rd_req, o_save, o_clear, o_calc_start, o_frame_done, o_busy}, 0);
    chk("rst_mid_addr", o_rd_addr, 0);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_win", {o_win_row, o_win_col}, 0);
    @(negedge clk) n_rst = 1'b1;
    run_frame(1'b0);
    check_frame_counts("after_rst");
    $display("[TB] frame after reset: reads=%0d calcs=%0d dones=%0d", n_reads, n_calcs, n_dones);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
